// File: rtl/volume_octave_control.sv
// volume_octave_control
//   Four pushbuttons step a volume (1..5) and an octave (1..3) value. Each button goes through
//   a 2-flop synchronizer and a counter debouncer. A rising edge of the debounced level issues
//   one step request.
//   Optional feature macro: AUTO_REPEAT_EN. When it is defined, a held button issues further
//   steps REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles.
//
// Ports
//   clk           : single clock
//   rst           : synchronous active-high reset
//   btn_vol_up    : raw button, 1 = pressed
//   btn_vol_down  : raw button, 1 = pressed
//   btn_oct_up    : raw button, 1 = pressed
//   btn_oct_down  : raw button, 1 = pressed
//   volume        : registered volume, 1..5 (reset 3)
//   octave        : registered octave, 1..3 (reset 2)
//   changed       : one-cycle pulse, high while a new volume/octave value is first shown
module volume_octave_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_vol_up,
  input  logic       btn_vol_down,
  input  logic       btn_oct_up,
  input  logic       btn_oct_down,
  output logic [2:0] volume,
  output logic [2:0] octave,
  output logic       changed
);

  localparam logic [15:0] DbLast = 16'(DEBOUNCE_CYCLES - 1);

  // Button index: 0 vol_up, 1 vol_down, 2 oct_up, 3 oct_down (opposite button is index ^ 1).
  logic [3:0]  w_raw;
  logic [3:0]  r_sync1, r_sync2;
  logic [3:0]  r_db, r_db_q;
  logic [15:0] r_cnt [4];
  logic [3:0]  w_step;
  logic [3:0]  w_rpt;
  logic [2:0]  r_vol, r_oct;
  logic        r_chg;
  logic [2:0]  w_vol_nxt, w_oct_nxt;

  assign w_raw = {btn_oct_down, btn_oct_up, btn_vol_down, btn_vol_up};

  // Synchronizers and debouncers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DbLast) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] RptFirst = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RptNext  = 32'(REPEAT_PERIOD - 1);

  logic [31:0] r_rpt_cnt [4];
  logic [3:0]  r_rpt_first;
  logic [3:0]  w_rpt_due;

  // The counter restarts on the cycle the initial step is applied, so it reads k
  // k cycles after that step; a due count raises the request one cycle ahead.
  always_comb begin
    w_rpt_due = '0;
    w_rpt     = '0;
    for (int i = 0; i < 4; i++) begin
      w_rpt_due[i] = r_db[i] & r_db_q[i] &
                     (r_rpt_cnt[i] == (r_rpt_first[i] ? RptFirst : RptNext));
      // Opposing buttons held together never repeat.
      w_rpt[i]     = w_rpt_due[i] & ~r_db[i ^ 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_first <= '1;
      for (int i = 0; i < 4; i++) r_rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!(r_db[i] && r_db_q[i])) begin
          r_rpt_cnt[i]   <= '0;
          r_rpt_first[i] <= 1'b1;
        end else if (w_rpt_due[i]) begin
          r_rpt_cnt[i]   <= '0;
          r_rpt_first[i] <= 1'b0;
        end else begin
          r_rpt_cnt[i]   <= r_rpt_cnt[i] + 32'd1;
        end
      end
    end
  end
`else
  assign w_rpt = '0;
`endif

  assign w_step = (r_db & ~r_db_q) | w_rpt;

  // Saturating steps; simultaneous up and down on one channel cancel.
  always_comb begin
    w_vol_nxt = r_vol;
    if (w_step[0] && !w_step[1] && r_vol != 3'd5) w_vol_nxt = r_vol + 3'd1;
    else if (w_step[1] && !w_step[0] && r_vol != 3'd1) w_vol_nxt = r_vol - 3'd1;
    w_oct_nxt = r_oct;
    if (w_step[2] && !w_step[3] && r_oct != 3'd3) w_oct_nxt = r_oct + 3'd1;
    else if (w_step[3] && !w_step[2] && r_oct != 3'd1) w_oct_nxt = r_oct - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vol <= 3'd3;
      r_oct <= 3'd2;
      r_chg <= 1'b0;
    end else begin
      r_vol <= w_vol_nxt;
      r_oct <= w_oct_nxt;
      r_chg <= (w_vol_nxt != r_vol) || (w_oct_nxt != r_oct);
    end
  end

  assign volume  = r_vol;
  assign octave  = r_oct;
  assign changed = r_chg;

endmodule

// File: tb/tb_volume_octave_control.sv
// Bench for volume_octave_control with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// The reference model works on whole presses: a press held for at least DEBOUNCE_CYCLES
// sampled cycles applies its request DEBOUNCE_CYCLES+3 edges after its first sampling edge.
module tb_volume_octave_control;

  localparam int Db    = 4;
  localparam int Lat   = Db + 3;
  localparam int Delay = 20;
  localparam int Per   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_vol_up, btn_vol_down, btn_oct_up, btn_oct_down;
  logic [2:0] volume, octave;
  logic       changed;

  int checks = 0;
  int errors = 0;

  int exp_vol, exp_oct;
  logic exp_chg;

  volume_octave_control #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Delay),
    .REPEAT_PERIOD  (Per)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_vol_up  (btn_vol_up),
    .btn_vol_down(btn_vol_down),
    .btn_oct_up  (btn_oct_up),
    .btn_oct_down(btn_oct_down),
    .volume      (volume),
    .octave      (octave),
    .changed     (changed)
  );

  always #5 clk = ~clk;

  // Button mask bits: 0 vol_up, 1 vol_down, 2 oct_up, 3 oct_down.
  task automatic tick(input logic [3:0] b, input logic r);
    rst = r;
    {btn_oct_down, btn_oct_up, btn_vol_down, btn_vol_up} = b;
    @(posedge clk);
    #1;
  endtask

  // Apply one step request to the model: net direction per channel, clamped to range.
  function automatic void model_apply(input logic [3:0] req);
    int dv, doc, nv, no;
    dv  = int'(req[0]) - int'(req[1]);
    doc = int'(req[2]) - int'(req[3]);
    nv  = exp_vol + dv;
    no  = exp_oct + doc;
    if (nv > 5) nv = 5;
    if (nv < 1) nv = 1;
    if (no > 3) no = 3;
    if (no < 1) no = 1;
    exp_chg = (nv != exp_vol) || (no != exp_oct);
    exp_vol = nv;
    exp_oct = no;
  endfunction

  task automatic do_reset();
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    exp_vol = 3;
    exp_oct = 2;
    exp_chg = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      tick(4'($urandom_range(0, 15)), 1'b1);
      checks++;
      if (volume !== 3'd3 || octave !== 3'd2 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset k=%0d vol=%0d oct=%0d chg=%0b required vol=3 oct=2 chg=0",
                 k, volume, octave, changed);
      end
    end
    exp_vol = 3;
    exp_oct = 2;
    for (int k = 0; k < Lat + 3; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (volume !== 3'd3 || octave !== 3'd2 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle k=%0d vol=%0d oct=%0d chg=%0b required vol=3 oct=2 chg=0",
                 k, volume, octave, changed);
      end
    end
  endtask

  task automatic test_single_press();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick((k <= 10) ? 4'b0001 : 4'b0000, 1'b0);
      exp_chg = 1'b0;
      if (k == Lat) model_apply(4'b0001);
      checks++;
      if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
        errors++;
        $display("FAIL single_press edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                 k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick((k <= Db - 1) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if (volume !== 3'd3 || octave !== 3'd2 || changed !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge=%0d vol=%0d oct=%0d chg=%0b required vol=3 oct=2 chg=0",
                 k, volume, octave, changed);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] m;
    do_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m = (ch == 0) ? 4'b0001 : 4'b1000;
      for (int p = 0; p < 6; p++) begin
        for (int k = 1; k <= 20; k++) begin
          tick((k <= 10) ? m : 4'b0000, 1'b0);
          exp_chg = 1'b0;
          if (k == Lat) model_apply(m);
          checks++;
          if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
            errors++;
            $display("FAIL saturation ch=%0d press=%0d edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                     ch, p, k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick((k <= 10) ? 4'b0111 : 4'b0000, 1'b0);
      exp_chg = 1'b0;
      if (k == Lat) model_apply(4'b0111);
      if (changed === 1'b1) pulses++;
      checks++;
      if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
        errors++;
        $display("FAIL simultaneous edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                 k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
      end
    end
    checks++;
    if (pulses != 1 || exp_vol != 3 || exp_oct != 3) begin
      errors++;
      $display("FAIL simultaneous_pulses pulses=%0d vol=%0d oct=%0d required 1 3 3",
               pulses, exp_vol, exp_oct);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(4'b0100, 1'b1);
      checks++;
      if (octave !== 3'd2 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_in_rst k=%0d oct=%0d chg=%0b required oct=2 chg=0",
                 k, octave, changed);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      tick(4'b0100, 1'b0);
      exp_chg = 1'b0;
      if (k == Lat) model_apply(4'b0100);
      checks++;
      if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
        errors++;
        $display("FAIL reset_hold edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                 k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
      end
    end
    for (int k = 0; k < 12; k++) tick(4'b0000, 1'b0);
  endtask

  // Reset arriving mid-debounce drops the pending step.
  task automatic test_reset_abandon();
    do_reset();
    model_apply(4'b0001);
    model_apply(4'b1000);
    for (int k = 1; k <= Db + 1; k++) tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b1);
    exp_vol = 3;
    exp_oct = 2;
    exp_chg = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (volume !== 3'd3 || octave !== 3'd2 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_abandon edge=%0d vol=%0d oct=%0d chg=%0b required vol=3 oct=2 chg=0",
                 k, volume, octave, changed);
      end
    end
  endtask

  task automatic test_auto_repeat();
    bit step;
    do_reset();
    for (int k = 1; k <= 75; k++) begin
      tick((k <= 60) ? 4'b0010 : 4'b0000, 1'b0);
      exp_chg = 1'b0;
      step = (k == Lat);
`ifdef AUTO_REPEAT_EN
      if (k >= Lat + Delay && k <= 60 && ((k - Lat - Delay) % Per) == 0) step = 1'b1;
`endif
      if (step) model_apply(4'b0010);
      checks++;
      if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
        errors++;
        $display("FAIL auto_repeat edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                 k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
      end
    end
`ifdef AUTO_REPEAT_EN
    checks++;
    if (volume !== 3'd1) begin
      errors++;
      $display("FAIL auto_repeat_final vol=%0d required 1", volume);
    end
`else
    checks++;
    if (volume !== 3'd2) begin
      errors++;
      $display("FAIL single_step_final vol=%0d required 2", volume);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] m;
    int len, gap;
    do_reset();
    for (int p = 0; p < 40; p++) begin
      m   = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 12);
      gap = $urandom_range(8, 14);
      for (int k = 1; k <= len + gap; k++) begin
        tick((k <= len) ? m : 4'b0000, 1'b0);
        exp_chg = 1'b0;
        if (k == Lat && len >= Db) model_apply(m);
        checks++;
        if (volume !== 3'(exp_vol) || octave !== 3'(exp_oct) || changed !== exp_chg) begin
          errors++;
          $display("FAIL random press=%0d mask=%b len=%0d edge=%0d vol=%0d oct=%0d chg=%0b required %0d %0d %0b",
                   p, m, len, k, volume, octave, changed, exp_vol, exp_oct, exp_chg);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_vol_up = 1'b0;
    btn_vol_down = 1'b0;
    btn_oct_up = 1'b0;
    btn_oct_down = 1'b0;
    exp_vol = 3;
    exp_oct = 2;
    exp_chg = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_saturation();
    test_simultaneous();
    test_reset_hold();
    test_reset_abandon();
    test_auto_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
